// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg
//   Shared constants for the branch resolution / predictor training slice:
//   conditional-branch opcode, chooser codes, FSM state codes and the
//   chooser-training helper.
package branch_resolve_unit_pkg;

   localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
   localparam logic [31:0] ZERO_WORD     = '0;

   typedef logic [1:0] chooser_t;

   localparam chooser_t CHOOSE_NONE   = 2'b00;
   localparam chooser_t CHOOSE_GLOBAL = 2'b01;
   localparam chooser_t CHOOSE_LOCAL  = 2'b10;

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_REDIRECT = 1'b1;

   // Train the chooser only when exactly one component got the direction right.
   function automatic chooser_t chooser_code(input logic global_pred,
                                             input logic local_pred,
                                             input logic taken);
      chooser_t code;
      code = CHOOSE_NONE;
      if ((global_pred == taken) && (local_pred != taken))
         code = CHOOSE_GLOBAL;
      else if ((local_pred == taken) && (global_pred != taken))
         code = CHOOSE_LOCAL;
      return code;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if
//   Predictor table-write channel (valid/ready).
//   master : drives upd_valid/upd_pc/upd_ghr/upd_taken/upd_chooser, sees upd_ready
//   slave  : the predictor side, drives upd_ready
interface branch_resolve_unit_if #(
   parameter int HIST_W = 12
);
   import branch_resolve_unit_pkg::*;

   logic              upd_valid;
   logic              upd_ready;
   logic [31:0]       upd_pc;
   logic [HIST_W-1:0] upd_ghr;
   logic              upd_taken;
   chooser_t          upd_chooser;

   modport master (
      output upd_valid, upd_pc, upd_ghr, upd_taken, upd_chooser,
      input  upd_ready
   );

   modport slave (
      input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_chooser,
      output upd_ready
   );

endinterface

// File: rtl/branch_resolve_unit_pdt_update_fifo.sv
// pdt_update_fifo
//   Synchronous FIFO, asynchronous active-high reset, first-word fall-through.
//   Ports: clk, rst, push/wr_data, pop/rd_data (head entry), full, empty.
//   Pointers carry one extra MSB so full and empty are told apart by it.
module pdt_update_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves conditional branches in EX against the IF prediction, issues a
//   one-cycle registered flush/redirect plus GHR restore on a mispredict, and
//   queues training records for the predictor table-write port.
//   Ports: clk, rst (async, active-high); ex_* resolved branch from EX;
//   upd (interface master) training channel; flush/redirect_pc and
//   ghr_restore_valid/ghr_restore to IF; stallreq to ctrl; branch_cnt and
//   mispredict_cnt statistics.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int HIST_W = 12,
   parameter int QDEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ex_branch_valid,
   input  logic [31:0]            ex_pc,
   input  logic                   ex_taken,
   input  logic [31:0]            ex_target,
   input  logic                   ex_pdt_taken,
   input  logic [31:0]            ex_pdt_pc,
   input  logic [HIST_W-1:0]      ex_pdt_ghr,
   input  logic                   ex_global_pred,
   input  logic                   ex_local_pred,
   branch_resolve_unit_if.master  upd,
   output logic                   flush,
   output logic [31:0]            redirect_pc,
   output logic                   ghr_restore_valid,
   output logic [HIST_W-1:0]      ghr_restore,
   output logic                   stallreq,
   output logic [31:0]            branch_cnt,
   output logic [31:0]            mispredict_cnt
);

   localparam int REC_W = 32 + HIST_W + 1 + 2;

   logic [0:0]       state;
   logic             accept;
   logic             mis;
   logic             pop;
   logic             q_full;
   logic             q_empty;
   logic [31:0]      correct_pc;
   logic [REC_W-1:0] wr_rec;
   logic [REC_W-1:0] rd_rec;

   // flush is a decode of the registered state, so it is glitch-free and
   // lands exactly one cycle after the mispredicting EX cycle.
   assign flush             = (state == ST_REDIRECT);
   assign ghr_restore_valid = flush;

   assign pop      = upd.upd_valid & upd.upd_ready;
   assign stallreq = ex_branch_valid & q_full & ~pop & ~flush;
   assign accept   = ex_branch_valid & ~stallreq & ~flush;
   assign mis      = accept & ((ex_taken != ex_pdt_taken) |
                               (ex_taken & (ex_target != ex_pdt_pc)));
   assign correct_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

   assign wr_rec = {ex_pc, ex_pdt_ghr, ex_taken,
                    chooser_code(ex_global_pred, ex_local_pred, ex_taken)};

   assign upd.upd_valid = ~q_empty;
   assign {upd.upd_pc, upd.upd_ghr, upd.upd_taken, upd.upd_chooser} = rd_rec;

   pdt_update_fifo #(
      .WIDTH (REC_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (accept),
      .wr_data (wr_rec),
      .pop     (pop),
      .rd_data (rd_rec),
      .full    (q_full),
      .empty   (q_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         redirect_pc    <= ZERO_WORD;
         ghr_restore    <= '0;
         branch_cnt     <= ZERO_WORD;
         mispredict_cnt <= ZERO_WORD;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mis) begin
                  state       <= ST_REDIRECT;
                  redirect_pc <= correct_pc;
                  ghr_restore <= {ex_pdt_ghr[HIST_W-2:0], ex_taken};
               end
            end
            ST_REDIRECT: state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
         if (accept) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mis) mispredict_cnt <= mispredict_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//   Directed plus randomized stimulus; a reference model advances on the
//   falling edge and pushes expected training records into a scoreboard that
//   a separate monitor drains whenever the DUT completes a table write.
module tb_branch_resolve_unit;

   localparam int HIST_W = 12;
   localparam int QDEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [11:0] ghr;
      logic        taken;
      logic [1:0]  ch;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_branch_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pdt_taken;
   logic [31:0] ex_pdt_pc;
   logic [11:0] ex_pdt_ghr;
   logic        ex_global_pred;
   logic        ex_local_pred;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        ghr_restore_valid;
   logic [11:0] ghr_restore;
   logic        stallreq;
   logic [31:0] branch_cnt;
   logic [31:0] mispredict_cnt;

   branch_resolve_unit_if #(.HIST_W(HIST_W)) ui ();

   branch_resolve_unit #(
      .HIST_W (HIST_W),
      .QDEPTH (QDEPTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .ex_branch_valid   (ex_branch_valid),
      .ex_pc             (ex_pc),
      .ex_taken          (ex_taken),
      .ex_target         (ex_target),
      .ex_pdt_taken      (ex_pdt_taken),
      .ex_pdt_pc         (ex_pdt_pc),
      .ex_pdt_ghr        (ex_pdt_ghr),
      .ex_global_pred    (ex_global_pred),
      .ex_local_pred     (ex_local_pred),
      .upd               (ui.master),
      .flush             (flush),
      .redirect_pc       (redirect_pc),
      .ghr_restore_valid (ghr_restore_valid),
      .ghr_restore       (ghr_restore),
      .stallreq          (stallreq),
      .branch_cnt        (branch_cnt),
      .mispredict_cnt    (mispredict_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   rec_t        sbq[$];
   bit          run_model = 1'b0;
   int          m_count = 0;
   logic        m_flush = 1'b0;
   logic [31:0] m_redir = '0;
   logic [11:0] m_rghr = '0;
   logic [31:0] m_bcnt = '0;
   logic [31:0] m_mcnt = '0;

   task automatic model_clear();
      sbq.delete();
      m_count = 0;
      m_flush = 1'b0;
      m_redir = '0;
      m_rghr  = '0;
      m_bcnt  = '0;
      m_mcnt  = '0;
   endtask

   always @(negedge clk) begin
      logic es, pop, acc, mis;
      rec_t r;
      if (run_model && !rst) begin
         es = ex_branch_valid && (m_count == QDEPTH) && !(m_count > 0 && ui.upd_ready) && !m_flush;
         check("stallreq", stallreq, es);
         check("flush", flush, m_flush);
         check("ghr_restore_valid", ghr_restore_valid, m_flush);
         if (m_flush) begin
            check("redirect_pc", redirect_pc, m_redir);
            check("ghr_restore", ghr_restore, m_rghr);
         end
         check("upd_valid", ui.upd_valid, m_count > 0);
         check("branch_cnt", branch_cnt, m_bcnt);
         check("mispredict_cnt", mispredict_cnt, m_mcnt);

         pop = (m_count > 0) && ui.upd_ready;
         acc = ex_branch_valid && !es && !m_flush;
         mis = acc && ((ex_taken != ex_pdt_taken) || (ex_taken && ex_target != ex_pdt_pc));
         if (acc) begin
            r.pc    = ex_pc;
            r.ghr   = ex_pdt_ghr;
            r.taken = ex_taken;
            if (ex_global_pred == ex_taken && ex_local_pred != ex_taken)      r.ch = 2'b01;
            else if (ex_local_pred == ex_taken && ex_global_pred != ex_taken) r.ch = 2'b10;
            else                                                              r.ch = 2'b00;
            sbq.push_back(r);
            m_count++;
            m_bcnt++;
            if (mis) m_mcnt++;
         end
         if (pop) m_count--;
         if (mis) begin
            m_redir = ex_taken ? ex_target : ex_pc + 32'd4;
            m_rghr  = (ex_pdt_ghr << 1) | {11'd0, ex_taken};
         end
         m_flush = mis;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      rec_t e;
      if (run_model && !rst && ui.upd_valid && ui.upd_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL upd_unexpected: got pc %0h expected no record", ui.upd_pc);
         end else begin
            e = sbq.pop_front();
            check("upd_pc", ui.upd_pc, e.pc);
            check("upd_ghr", ui.upd_ghr, e.ghr);
            check("upd_taken", ui.upd_taken, e.taken);
            check("upd_chooser", ui.upd_chooser, e.ch);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ppc,
                        input logic [11:0] gh, input logic g, input logic l);
      ex_branch_valid = v;
      ex_pc           = pc;
      ex_taken        = t;
      ex_target       = tgt;
      ex_pdt_taken    = pt;
      ex_pdt_pc       = ppc;
      ex_pdt_ghr      = gh;
      ex_global_pred  = g;
      ex_local_pred   = l;
   endtask

   task automatic idle();
      ex_branch_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          hold;
      logic [31:0] pc, tgt, ppc;
      logic        t;
      int          sel;

      rst = 1'b1;
      ui.upd_ready = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      #2;
      check("rst_flush", flush, 1'b0);
      check("rst_upd_valid", ui.upd_valid, 1'b0);
      check("rst_stallreq", stallreq, 1'b0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_branch_cnt", branch_cnt, 32'd0);
      step();
      step();
      rst = 1'b0;
      run_model = 1'b1;

      // correct not-taken
      drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 12'h001, 1'b0, 1'b0);
      step();
      idle();
      step();

      // direction mispredict; a branch offered during flush must be dropped
      drive(1'b1, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204, 12'h0A5, 1'b0, 1'b1);
      step();
      drive(1'b1, 32'h250, 1'b0, 32'h0, 1'b0, 32'h254, 12'h0, 1'b0, 1'b0);
      #2;
      check("t2_flush", flush, 1'b1);
      check("t2_redirect", redirect_pc, 32'h180);
      check("t2_ghr_restore", ghr_restore, 12'h14B);
      step();
      idle();
      #2;
      check("t2_flush_one_cycle", flush, 1'b0);
      check("t2_branch_cnt", branch_cnt, 32'd2);
      step();

      // target mispredict, then not-taken predicted taken
      drive(1'b1, 32'h2F0, 1'b1, 32'h300, 1'b1, 32'h304, 12'h3C, 1'b1, 1'b1);
      step();
      idle();
      #2;
      check("t3_redirect_target", redirect_pc, 32'h300);
      step();
      drive(1'b1, 32'h400, 1'b0, 32'h480, 1'b1, 32'h480, 12'h7, 1'b0, 1'b1);
      step();
      idle();
      #2;
      check("t3_redirect_fallthru", redirect_pc, 32'h404);
      step();
      repeat (6) step();

      // queue full
      ui.upd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h500 + 32'(i * 16), 1'b1, 32'h900, 1'b1, 32'h900, 12'(i), 1'b1, 1'b0);
         step();
      end
      drive(1'b1, 32'h540, 1'b0, 32'h0, 1'b0, 32'h544, 12'h5, 1'b0, 1'b1);
      #2;
      check("t4_stall_full", stallreq, 1'b1);
      step();
      ui.upd_ready = 1'b1;
      #2;
      check("t4_stall_released", stallreq, 1'b0);
      step();
      ui.upd_ready = 1'b0;
      drive(1'b1, 32'h550, 1'b0, 32'h0, 1'b0, 32'h554, 12'h6, 1'b0, 1'b0);
      #2;
      check("t4_still_full", stallreq, 1'b1);
      idle();
      ui.upd_ready = 1'b1;
      repeat (6) step();

      // chooser training
      drive(1'b1, 32'h600, 1'b1, 32'h640, 1'b1, 32'h640, 12'h0, 1'b1, 1'b0);
      step();
      drive(1'b1, 32'h610, 1'b1, 32'h640, 1'b1, 32'h640, 12'h0, 1'b0, 1'b1);
      step();
      drive(1'b1, 32'h620, 1'b1, 32'h640, 1'b1, 32'h640, 12'h0, 1'b1, 1'b1);
      step();
      idle();
      repeat (5) step();

      // async reset in the middle of REDIRECT with 3 records queued
      ui.upd_ready = 1'b0;
      drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h704, 12'h1, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h710, 1'b0, 32'h0, 1'b0, 32'h714, 12'h2, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h720, 1'b1, 32'h7A0, 1'b0, 32'h724, 12'h3, 1'b0, 1'b0);
      step();
      idle();
      #1;
      check("t6_pre_flush", flush, 1'b1);
      rst = 1'b1;
      model_clear();
      #1;
      check("t6_flush", flush, 1'b0);
      check("t6_upd_valid", ui.upd_valid, 1'b0);
      check("t6_branch_cnt", branch_cnt, 32'd0);
      check("t6_mispredict_cnt", mispredict_cnt, 32'd0);
      check("t6_redirect_pc", redirect_pc, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      ui.upd_ready = 1'b1;
      repeat (3) step();

      // randomized traffic; EX holds a stalled branch until it is accepted
      hold = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (i < 300) ui.upd_ready = ($urandom_range(0, 3) == 0);
         else         ui.upd_ready = ($urandom_range(0, 3) != 0);
         if (!hold) begin
            pc  = $urandom() & 32'hFFFF_FFFC;
            tgt = $urandom() & 32'hFFFF_FFFC;
            t   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 2);
            ppc = (sel == 0) ? tgt : (sel == 1) ? pc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
            drive(($urandom_range(0, 2) != 0), pc, t, tgt, 1'($urandom_range(0, 1)), ppc,
                  12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         @(negedge clk);
         hold = stallreq;
         step();
      end
      idle();
      ui.upd_ready = 1'b1;
      repeat (8) step();
      check("final_drained", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
